// File: rtl/clock_display_pkg.sv
// Shared constants and types for the multiplexed HH:MM:SS seven-segment scanner.
package clock_display_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    typedef logic [2:0] digit_idx_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        unique case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/clock_bcd_split.sv
// Splits a 6-bit binary field into decimal tens/ones and flags it valid when value <= limit.
module clock_bcd_split (
    input  logic [5:0] value,
    input  logic [5:0] limit,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid
);

    always_comb begin
        tens  = 4'(value / 6'd10);
        ones  = 4'(value % 6'd10);
        valid = (value <= limit);
    end

endmodule

// File: rtl/clock_display_scan.sv
// Time-multiplexed six-digit HH:MM:SS scanner with frame-coherent snapshot.
// Optional COLON_BLINK_EN: colon follows even/odd snapshot seconds instead of enable.
module clock_display_scan
    import clock_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic [6:0] seg,
    output logic [5:0] dig_sel,
    output logic       colon
);

    localparam logic [15:0] CntMax  = 16'(SCAN_DIV - 1);
    localparam digit_idx_t  LastIdx = digit_idx_t'(NUM_DIGITS - 1);

    logic [15:0] cnt_q, cnt_d;
    digit_idx_t  idx_q, idx_d;
    logic [5:0]  snap_h_q, snap_h_d, snap_m_q, snap_m_d, snap_s_q, snap_s_d;
    logic        load_pending_q, load_pending_d;
    logic [6:0]  seg_q, seg_d;
    logic [5:0]  dig_sel_q, dig_sel_d;
    logic        colon_q, colon_d;

    logic [3:0] h_tens, h_ones, m_tens, m_ones, s_tens, s_ones;
    logic       h_valid, m_valid, s_valid;
    logic       cnt_wrap, snap_load;
    logic [3:0] digit_val;
    logic       digit_valid;
    logic [6:0] digit_seg;

    clock_bcd_split u_split_h (
        .value(snap_h_q), .limit(6'd23), .tens(h_tens), .ones(h_ones), .valid(h_valid)
    );
    clock_bcd_split u_split_m (
        .value(snap_m_q), .limit(6'd59), .tens(m_tens), .ones(m_ones), .valid(m_valid)
    );
    clock_bcd_split u_split_s (
        .value(snap_s_q), .limit(6'd59), .tens(s_tens), .ones(s_ones), .valid(s_valid)
    );

    always_comb begin
        cnt_wrap = (cnt_q == CntMax);
        cnt_d    = cnt_wrap ? 16'd0 : cnt_q + 16'd1;
        idx_d    = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == LastIdx) ? digit_idx_t'(0) : idx_q + digit_idx_t'(1);
        end

        // Reload only at a frame boundary so a frame never mixes two times.
        snap_load      = load_pending_q | (cnt_wrap & (idx_q == LastIdx));
        snap_h_d       = snap_load ? hours   : snap_h_q;
        snap_m_d       = snap_load ? minutes : snap_m_q;
        snap_s_d       = snap_load ? seconds : snap_s_q;
        load_pending_d = 1'b0;

        digit_val   = 4'd0;
        digit_valid = 1'b0;
        unique case (idx_q)
            3'd0:    begin digit_val = h_tens; digit_valid = h_valid; end
            3'd1:    begin digit_val = h_ones; digit_valid = h_valid; end
            3'd2:    begin digit_val = m_tens; digit_valid = m_valid; end
            3'd3:    begin digit_val = m_ones; digit_valid = m_valid; end
            3'd4:    begin digit_val = s_tens; digit_valid = s_valid; end
            3'd5:    begin digit_val = s_ones; digit_valid = s_valid; end
            default: begin digit_val = 4'd0;   digit_valid = 1'b0;    end
        endcase
        digit_seg = digit_valid ? seg_encode(digit_val) : SEG_DASH;

        seg_d     = enable ? digit_seg : 7'd0;
        dig_sel_d = enable ? (6'd1 << idx_q) : 6'd0;
`ifdef COLON_BLINK_EN
        colon_d   = enable & ~snap_s_q[0];
`else
        colon_d   = enable;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q          <= 16'd0;
            idx_q          <= digit_idx_t'(0);
            snap_h_q       <= 6'd0;
            snap_m_q       <= 6'd0;
            snap_s_q       <= 6'd0;
            load_pending_q <= 1'b1;
            seg_q          <= 7'd0;
            dig_sel_q      <= 6'd0;
            colon_q        <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            snap_h_q       <= snap_h_d;
            snap_m_q       <= snap_m_d;
            snap_s_q       <= snap_s_d;
            load_pending_q <= load_pending_d;
            seg_q          <= seg_d;
            dig_sel_q      <= dig_sel_d;
            colon_q        <= colon_d;
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;
    assign colon   = colon_q;

endmodule
